// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: controller state encoding,
// default sizes and the product-width helper.
package mult_pkg;

    localparam int WIDTH_DEF = 6;
    localparam int CNT_W_DEF = 3;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mult_datapath.sv
// Shift-and-add datapath: shifted multiplicand, draining multiplier and accumulator.
// One partial product is folded in per step through a 2:1 addend select.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic                       step,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic [prod_w(WIDTH)-1:0]   acc_nxt
);

    localparam int PW = prod_w(WIDTH);

    logic [PW-1:0]    mcand_sh_q, mcand_sh_d;
    logic [WIDTH-1:0] mplier_q,   mplier_d;
    logic [PW-1:0]    acc_q,      acc_d;
    logic [PW-1:0]    addend;

    // The low multiplier bit selects whether this step's shifted multiplicand counts.
    assign addend  = mplier_q[0] ? mcand_sh_q : '0;
    assign acc_nxt = acc_q + addend;

    always_comb begin
        // NOTE: every comb output is given its hold value first so no path leaves it unassigned (no latch).
        mcand_sh_d = mcand_sh_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        if (load) begin
            mcand_sh_d = {{WIDTH{1'b0}}, a};
            mplier_d   = b;
            acc_d      = '0;
        end else if (step) begin
            mcand_sh_d = mcand_sh_q << 1;
            mplier_d   = mplier_q >> 1;
            acc_d      = acc_nxt;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_sh_q <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
        end else begin
            mcand_sh_q <= mcand_sh_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
        end
    end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential multiplier top: IDLE/RUN/DONE controller, iteration counter,
// start/busy/done handshake and the held product register.
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       busy,
    output logic                       done,
    output logic [prod_w(WIDTH)-1:0]   product
);

    localparam int               PW   = prod_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [PW-1:0]    product_q, product_d;
    logic [PW-1:0]    acc_nxt;
    logic             load, step, last;

    mult_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .step    (step),
        .a       (a),
        .b       (b),
        .acc_nxt (acc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // start is only honoured outside RUN, so a request while busy is simply dropped.
    always_comb begin
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        load      = start && (state_q != RUN);
        step      = (state_q == RUN);
        last      = step && (cnt_q == LAST);
        cnt_d     = cnt_q;
        product_d = product_q;
        if (load) begin
            cnt_d = '0;
        end else if (step) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (last) begin
            product_d = acc_nxt;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed and exhaustive checks of the shift-and-add multiplier: latency,
// handshake, ignored starts, back-to-back operation and asynchronous abort.
module tb_shift_add_mult_ctrl;

    localparam int WIDTH = 6;
    localparam int PW    = 2 * WIDTH;
    localparam int LAT   = WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_i, b_i;
    logic             busy, done;
    logic [PW-1:0]    product;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int overlap  = 0;

    typedef struct {
        int a;
        int b;
        int exp_p;
    } vec_t;

    shift_add_mult_ctrl #(.WIDTH(WIDTH), .CNT_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a_i),
        .b       (b_i),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy && done) overlap++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Steps until done or the cycle bound; done_cyc stays -1 on timeout.
    task automatic wait_done(input int max_cyc, output int done_cyc, inout int busy_cnt);
        done_cyc = -1;
        while (done_cyc < 0 && cyc < max_cyc) begin
            step();
            if (busy) busy_cnt++;
            if (done) done_cyc = cyc;
        end
    endtask

    task automatic run_op(input int a, input int b, input int exp_p, input string name);
        int dc;
        int bc;
        cyc   = 0;
        start = 1'b1;
        a_i   = WIDTH'(a);
        b_i   = WIDTH'(b);
        step();
        start = 1'b0;
        bc    = busy ? 1 : 0;
        wait_done(20, dc, bc);
        check({name, "_latency"}, dc, LAT);
        check({name, "_busy_cycles"}, bc, WIDTH);
        check({name, "_product"}, int'(product), exp_p);
        step();
        check({name, "_done_single"}, int'(done), 0);
    endtask

    vec_t vecs[6];

    initial begin
        int dc, bc, n_done, first_done;

        vecs[0] = '{a: 5,  b: 7,  exp_p: 35};
        vecs[1] = '{a: 63, b: 63, exp_p: 3969};
        vecs[2] = '{a: 0,  b: 63, exp_p: 0};
        vecs[3] = '{a: 63, b: 0,  exp_p: 0};
        vecs[4] = '{a: 1,  b: 1,  exp_p: 1};
        vecs[5] = '{a: 63, b: 1,  exp_p: 63};

        rst_n = 1'b0;
        start = 1'b0;
        a_i   = '0;
        b_i   = '0;
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_product", int'(product), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("idle_busy", int'(busy), 0);

        // Latency and product for the directed vector table.
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp_p, $sformatf("vec%0d", i));
        end

        // A start pulse in cycle 3 of a running op must be dropped entirely.
        cyc = 0; start = 1'b1; a_i = 6'd3; b_i = 6'd4;
        step(); start = 1'b0;
        step(); step();
        start = 1'b1; a_i = 6'd9; b_i = 6'd9;
        step(); start = 1'b0;
        n_done = 0; first_done = -1;
        while (cyc < 16) begin
            step();
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = cyc;
            end
        end
        check("ignore_first_done", first_done, LAT);
        check("ignore_done_count", n_done, 1);
        check("ignore_product", int'(product), 12);
        check("ignore_idle_after", int'(busy), 0);

        // Back-to-back: start held, new operands presented while in DONE.
        cyc = 0; start = 1'b1; a_i = 6'd2; b_i = 6'd3;
        bc = 0;
        wait_done(20, dc, bc);
        check("b2b_first_done", dc, LAT);
        check("b2b_first_product", int'(product), 6);
        a_i = 6'd10; b_i = 6'd10;
        step();
        start = 1'b0;
        check("b2b_restart_busy", int'(busy), 1);
        check("b2b_product_held", int'(product), 6);
        bc = 1;
        wait_done(30, dc, bc);
        check("b2b_second_done", dc, 2 * LAT);
        check("b2b_second_product", int'(product), 100);
        step();

        // Asynchronous abort in cycle 3, then a clean rerun of the same operands.
        cyc = 0; start = 1'b1; a_i = 6'd50; b_i = 6'd40;
        step(); start = 1'b0;
        step(); step();
        check("abort_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_product", int'(product), 0);
        step();
        check("abort_done_held", int'(done), 0);
        rst_n = 1'b1;
        step();
        check("abort_still_idle", int'(busy), 0);
        run_op(50, 40, 2000, "rerun");

        // Full operand sweep against the arithmetic product.
        for (int x = 0; x < 64; x++) begin
            for (int y = 0; y < 64; y++) begin
                run_op(x, y, x * y, "sweep");
            end
        end

        check("busy_done_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
